// File: rtl/player_input_if.sv
// Key/enable inputs and press-pulse outputs of the two-player input block.
interface player_input_if;
  logic KeyL;
  logic KeyR;
  logic Enable;
  logic L;
  logic R;

  modport master (
    output KeyL,
    output KeyR,
    output Enable,
    input  L,
    input  R
  );

  modport slave (
    input  KeyL,
    input  KeyR,
    input  Enable,
    output L,
    output R
  );
endinterface

// File: rtl/player_input.sv
// Two-player key front end: synchronize, debounce, and emit one
// registered pulse per accepted press on each of L and R.
module player_input #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic     Clock,
  input logic     Reset,
  player_input_if.slave io
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic          key;
    logic          sync1;
    logic          sync2;
    logic          lvl;
    logic          pulse_d;
    logic          pulse_q;
    state_t        st_q;
    state_t        st_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign key = (i == 0) ? io.KeyL : io.KeyR;
    assign lvl = (st_q == PRESSED);

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        st_q    <= RELEASED;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        sync1   <= key;
        sync2   <= sync1;
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    // Any agreeing cycle clears the count; only a full run toggles.
    always_comb begin
      st_d    = st_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (sync2 != lvl) begin
        if (cnt_q == LAST) begin
          unique case (st_q)
            RELEASED: begin
              st_d    = PRESSED;
              pulse_d = io.Enable;
            end
            PRESSED: st_d = RELEASED;
            default: st_d = RELEASED;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  assign io.L = g_ch[0].pulse_q;
  assign io.R = g_ch[1].pulse_q;

endmodule
